// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: md_op encodings and operand-op width.
// Decode logic and the hazard controller use these, as well as md_unit.
package md_unit_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_unit_counter.sv
// Loadable down-counter that stops at zero. Used as the busy timer of md_unit.
module md_unit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  // Clear wins over load; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at accept time and held in a pending register; it is
// written to HI/LO only when the busy timer expires, so a cancel or reset
// during the op leaves HI/LO at their pre-op values.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int MAX_CYC = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0]      count;
  logic               zero;
  logic               accept;
  logic               is_arith;
  logic               is_div;
  logic               commit;
  logic [CW-1:0]      load_val;

  logic [WIDTH-1:0]   pend_hi;
  logic [WIDTH-1:0]   pend_lo;
  logic               pend_wr;

  // Multiply: sign- or zero-extend both operands to the full product width.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Divide: signed case works on magnitudes, then fixes signs. A zero divisor
  // is replaced by one only to keep the operators defined; its result is
  // never committed. Most-negative / -1 falls out as quotient = most-negative.
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, b_mag_safe;
  logic [WIDTH-1:0]   q_u, r_u, q_m, r_m, q_s, r_s;
  assign a_neg      = a[WIDTH-1];
  assign b_neg      = b[WIDTH-1];
  assign b_zero     = (b == '0);
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign b_safe     = b_zero ? WIDTH'(1) : b;
  assign b_mag_safe = b_zero ? WIDTH'(1) : b_mag;
  assign q_u        = a / b_safe;
  assign r_u        = a % b_safe;
  assign q_m        = a_mag / b_mag_safe;
  assign r_m        = a_mag % b_mag_safe;
  assign q_s        = (a_neg ^ b_neg) ? -q_m : q_m;
  assign r_s        = a_neg ? -r_m : r_m;

  assign busy     = !zero;
  assign accept   = start && !busy && !cancel;
  assign is_arith = (md_op <= MD_OP_W'(MD_DIVU));
  assign is_div   = (md_op == MD_OP_W'(MD_DIV)) || (md_op == MD_OP_W'(MD_DIVU));
  assign load_val = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  assign commit   = (count == CW'(1)) && !cancel;

  md_unit_counter #(.CW(CW)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && is_arith),
    .load_val (load_val),
    .clear    (cancel),
    .count    (count),
    .zero     (zero)
  );

  // HI/LO and pending-result update: cancel discards, timer expiry commits,
  // an idle accept captures a result or performs MTHI/MTLO directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (cancel) begin
      pend_wr <= 1'b0;
    end else if (commit) begin
      if (pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      pend_wr <= 1'b0;
    end else if (accept) begin
      case (md_op_e'(md_op))
        MD_MULT: begin
          pend_hi <= prod_s[2*WIDTH-1:WIDTH];
          pend_lo <= prod_s[WIDTH-1:0];
          pend_wr <= 1'b1;
        end
        MD_MULTU: begin
          pend_hi <= prod_u[2*WIDTH-1:WIDTH];
          pend_lo <= prod_u[WIDTH-1:0];
          pend_wr <= 1'b1;
        end
        MD_DIV: begin
          pend_hi <= r_s;
          pend_lo <= q_s;
          pend_wr <= !b_zero;
        end
        MD_DIVU: begin
          pend_hi <= r_u;
          pend_lo <= q_u;
          pend_wr <= !b_zero;
        end
        MD_MTHI: hi <= a;
        MD_MTLO: lo <= a;
        default: ;
      endcase
    end
  end

endmodule
